// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and the bitwise opcode encodings.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
  localparam logic [OP_W-1:0] OP_AND  = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_NAND = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b101;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_op_core.sv
// Combinational WIDTH-bit bitwise operation decode; shared with the ALU top.
import alu_pkg::*;

module logic_op_core #(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] x
);

  // Select the bitwise result for the opcode; no carries between bits.
  always_comb begin
    x = '0;
    case (op)
      OP_NOT:  x = ~a;
      OP_AND:  x = a & b;
      OP_OR:   x = a | b;
      OP_XOR:  x = a ^ b;
      OP_NAND: x = ~(a & b);
      OP_NOR:  x = ~(a | b);
      OP_XNOR: x = ~(a ^ b);
      OP_PASS: x = a;
      default: x = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake on both
// sides. S1 captures operands, S2 captures the result and its flags.
// Optional feature macro: PIPELINED_LOGIC_UNIT_COUNT_EN registers the result
// popcount onto out_count; without it out_count is held at zero.
import alu_pkg::*;

module pipelined_logic_unit #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [CW-1:0]    out_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] core_x;
  logic [CW-1:0]    core_count;
  logic             s1_adv;
  logic             s2_adv;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .op (s1_op_q),
    .a  (s1_a_q),
    .b  (s1_b_q),
    .x  (core_x)
  );

  // Popcount of the S2 input result, or a constant zero when the feature is off.
  always_comb begin
    core_count = '0;
`ifdef PIPELINED_LOGIC_UNIT_COUNT_EN
    for (int i = 0; i < WIDTH; i++) begin
      core_count = core_count + CW'(core_x[i]);
    end
`endif
  end

  // Handshake: a stage advances when empty or when the stage after it moves.
  // in_ready is forced low during reset so nothing is accepted then.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv && !reset;
  end

  // Next-state for both stages; data registers only load behind a valid item.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    x_d        = x_q;
    zero_d     = zero_q;
    ones_d     = ones_q;
    parity_d   = parity_q;
    count_d    = count_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = in_op;
        s1_a_d  = in_a;
        s1_b_d  = in_b;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        x_d      = core_x;
        zero_d   = (core_x == '0);
        ones_d   = &core_x;
        parity_d = ^core_x;
        count_d  = core_count;
      end
    end
  end

  // Pipeline registers with synchronous reset clearing valids and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      zero_q     <= 1'b0;
      ones_q     <= 1'b0;
      parity_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      x_q        <= x_d;
      zero_q     <= zero_d;
      ones_q     <= ones_d;
      parity_q   <= parity_d;
      count_q    <= count_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_x      = x_q;
  assign out_zero   = zero_q;
  assign out_ones   = ones_q;
  assign out_parity = parity_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Scoreboard bench for pipelined_logic_unit (WIDTH=8 main instance plus a
// WIDTH=16 instance for the wide all-ones XOR case).
module tb_pipelined_logic_unit;

  typedef struct packed {
    logic [7:0] x;
    logic       z;
    logic       o;
    logic       p;
    logic [3:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  in_op;
  logic [7:0]  in_a, in_b, out_x;
  logic        out_zero, out_ones, out_parity;
  logic [3:0]  out_count;

  logic        v16, r16, ov16, or16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, x16;
  logic        z16, o16, p16;
  logic [4:0]  c16;

  int   errors = 0;
  int   checks = 0;
  int   pushed = 0;
  int   dropped = 0;
  int   pops = 0;
  int   cyc = 0;
  int   last_pop_cyc = -10;
  int   run = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_logic_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_zero(out_zero),
    .out_ones(out_ones), .out_parity(out_parity), .out_count(out_count)
  );

  pipelined_logic_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(v16), .in_ready(r16),
    .in_op(op16), .in_a(a16), .in_b(b16), .out_valid(ov16),
    .out_ready(or16), .out_x(x16), .out_zero(z16),
    .out_ones(o16), .out_parity(p16), .out_count(c16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] x);
    exp_t e;
    e.x = x;
    e.z = (x == 8'h00);
    e.o = (x == 8'hFF);
    e.p = ^x;
`ifdef PIPELINED_LOGIC_UNIT_COUNT_EN
    e.c = 4'($countones(x));
`else
    e.c = 4'd0;
`endif
    return e;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    case (op)
      3'd0: x = ~a;
      3'd1: x = a & b;
      3'd2: x = a | b;
      3'd3: x = a ^ b;
      3'd4: x = ~(a & b);
      3'd5: x = ~(a | b);
      3'd6: x = ~(a ^ b);
      default: x = a;
    endcase
    return mk(x);
  endfunction

  // Issue one item and push its expectation at the accepting edge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input exp_t e, output int waited);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", 32'(waited), 32'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(e);
      pushed++;
      #1;
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops and compares on every output handshake, and checks that a
  // stalled output keeps its value and flags.
  initial begin
    exp_t e;
    logic prev_held;
    exp_t held;
    prev_held = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_held = 1'b0;
      end else begin
        if (prev_held && out_valid) begin
          check("hold_x", 32'(out_x), 32'(held.x));
          check("hold_flags", {out_zero, out_ones, out_parity, out_count},
                {held.z, held.o, held.p, held.c});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output: got x=%0h with nothing expected (t=%0t)", out_x, $time);
          end else begin
            e = sb.pop_front();
            check("out_x", 32'(out_x), 32'(e.x));
            check("out_zero", 32'(out_zero), 32'(e.z));
            check("out_ones", 32'(out_ones), 32'(e.o));
            check("out_parity", 32'(out_parity), 32'(e.p));
            check("out_count", 32'(out_count), 32'(e.c));
          end
          pops++;
          run = (cyc == last_pop_cyc + 1) ? run + 1 : 1;
          last_pop_cyc = cyc;
        end
        prev_held = out_valid && !out_ready;
        held = '{x: out_x, z: out_zero, o: out_ones, p: out_parity, c: out_count};
      end
    end
  end

  logic [7:0] sweep_x [8];
  int w;

  initial begin
    sweep_x = '{8'h3C, 8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'hC3};
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; or16 = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    check("out_valid_in_reset", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    check("reset_outputs", {out_valid, out_x, out_zero, out_ones, out_parity, out_count}, 32'd0);
    @(posedge clk); #1;

    // NOT 00 -> FF with two-cycle latency
    send(3'd0, 8'h00, 8'h00, mk(8'hFF), w);
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // Opcode sweep with hand-computed results
    for (int i = 0; i < 8; i++) send(3'(i), 8'hC3, 8'h5A, mk(sweep_x[i]), w);
    drain();

    // Back-to-back 10 items
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      send(3'(i % 8), 8'(i * 37 + 5), 8'(i * 91 + 3),
           model(3'(i % 8), 8'(i * 37 + 5), 8'(i * 91 + 3)), w);
      check("b2b_in_ready", 32'(w), 32'd0);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_consecutive", 32'(run >= 10), 32'd1);
    drain();

    // Backpressure: two items fill the pipe, then in_ready holds low
    out_ready = 1'b0;
    send(3'd1, 8'hF0, 8'h3C, model(3'd1, 8'hF0, 8'h3C), w);
    send(3'd3, 8'hA5, 8'h0F, model(3'd3, 8'hA5, 8'h0F), w);
    in_valid = 1'b1; in_op = 3'd5; in_a = 8'h12; in_b = 8'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd5, 8'h12, 8'h40, model(3'd5, 8'h12, 8'h40), w);
    check("accept_on_drain", 32'(w), 32'd0);
    drain();
    check("no_loss_dup", 32'(pops), 32'(pushed - dropped));

    // Reset with both stages full discards both items
    out_ready = 1'b0;
    send(3'd2, 8'h81, 8'h18, model(3'd2, 8'h81, 8'h18), w);
    send(3'd6, 8'h77, 8'h70, model(3'd6, 8'h77, 8'h70), w);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_before_reset", {out_valid, in_ready}, 32'b10);
    reset = 1'b1;
    dropped += sb.size();
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_valid", 32'(out_valid), 32'd0);
    check("reset_mid_x", 32'(out_x), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // WIDTH=16 XOR FFFF^FFFF
    v16 = 1'b1; op16 = 3'd3; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk);
    check("w16_in_ready", 32'(r16), 32'd1);
    @(posedge clk); #1;
    v16 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("w16_valid", 32'(ov16), 32'd1);
    check("w16_x", 32'(x16), 32'd0);
    check("w16_flags", {z16, o16, p16, c16}, {1'b1, 1'b0, 1'b0, 5'd0});

    check("final_queue_empty", 32'(sb.size()), 32'd0);
    check("final_pop_count", 32'(pops), 32'(pushed - dropped));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_logic_unit.md
# pipelined_logic_unit

Parametrised, pipelined bitwise logic unit for the ALU datapath; successor to the fixed 8-bit combinational inverter. It accepts two WIDTH-bit operands and a 3-bit opcode under a valid/ready handshake. It returns the registered result plus zero, all-ones and parity flags after two cycles. Full backpressure lets it sit between the operand sequencer and the ALU result mux without stalling logic elsewhere.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all valid state
- in_valid  in  1  operand/op presented
- in_ready  out  1  unit can accept this cycle
- in_op  in  3  opcode (see Operation)
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored by NOT/PASS)
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- out_x  out  WIDTH  result
- out_zero  out  1  out_x == 0
- out_ones  out  1  out_x all ones
- out_parity  out  1  XOR-reduction of out_x
- out_count  out  $clog2(WIDTH+1)  set-bit count of out_x (see Configuration)

## Operation
- Opcodes: 000 NOT a; 001 a AND b; 010 a OR b; 011 a XOR b; 100 NAND; 101 NOR; 110 XNOR; 111 PASS a.
- Stage 1 (S1): registers in_op, in_a, in_b and s1_valid on input handshake (in_valid & in_ready).
- Stage 2 (S2): computes op from S1 registers; registers out_x, flags and s2_valid.
- Advance rules: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
- S2 loads when s2_adv: s2_valid <= s1_valid; data loads only if s1_valid.
- S1 loads when s1_adv: s1_valid <= in_valid; data loads only if in_valid.
- Held outputs: while out_valid & !out_ready, out_x and all flags stay stable.
- Flags derive from the registered result only, never from live inputs.
- Arithmetic: purely bitwise, no carry. All operations stay WIDTH-bit.
- Reset: s1_valid = s2_valid = 0. out_x, flags and out_count = 0. in_ready = 1 in the cycle after reset deasserts. While reset is high, in_ready = 0.
- Reset mid-operation: in-flight items are discarded and never presented.

## Timing
- Latency: input handshake at edge N gives out_valid high after edge N+1 (visible in cycle N+1), with out_ready held high.
- Throughput: one result per cycle under continuous in_valid/out_ready.
- in_ready depends combinationally on out_ready. No combinational path exists from in_* to out_*.
- Full: both stages valid and out_ready low gives in_ready = 0. Capacity is 2 items.
- Simultaneous accept and drain when full: out_ready high lets a new item enter S1 in the same edge as S2 drains and S1 moves up.

## Configuration
- PIPELINED_LOGIC_UNIT_COUNT_EN defined: S2 additionally registers the popcount of the result onto out_count. This adds one adder tree of depth log2(WIDTH).
- Not defined: out_count is tied to 0. The port remains so that instantiations are identical.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams: OP_NOT, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_PASS
  - the 3-bit opcode width constant
- One sub-module, logic_op_core: combinational WIDTH-parametrised op decode. It is reused later by the ALU top.
- Pipeline registers and handshake logic live in pipelined_logic_unit.

## Test plan
- Reset then NOT, WIDTH=8, a=8'h00 -> out_x=8'hFF, out_ones=1, out_parity=0, out_count=8 (macro on), 2 cycles later.
- Sweep all 8 ops with a=8'hC3, b=8'h5A -> results:
  - NOT 3C, AND 42, OR DB, XOR 99
  - NAND BD, NOR 24, XNOR 66, PASS C3
- Back-to-back 10 items with out_ready=1 -> 10 results on consecutive cycles, in order, with in_ready always 1.
- Hold out_ready=0 for 5 cycles while feeding items:
  - in_ready drops after 2 accepted items
  - out_x stays stable
  - releasing out_ready drains both items in order with no loss or duplicate
- Assert reset for 1 cycle with both stages valid -> out_valid=0 next cycle, out_x=0, and neither in-flight result ever appears.
- WIDTH=16, XOR a=16'hFFFF, b=16'hFFFF -> out_x=0, out_zero=1, out_parity=0, out_count=0.
